pwm_deadtime_out: RTL and testbench

- Output stage directly downstream of the PWM core. Consumes pwm_raw and period_end; produces a complementary high-side/low-side gate pair with programmable dead-time insertion, per-output polarity and a latched fault shutdown.
- Configuration is shadowed and applied only at period boundaries, so runtime writes never produce runt or overlapping pulses.

---
 rtl/pwm_pkg.sv | 12 +
 rtl/pwm_deadtime_cnt.sv | 30 +++
 rtl/pwm_deadtime_out.sv | 111 +++++++++++
 tb/tb_pwm_deadtime_out.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types for the PWM dead-time output stage.
package pwm_pkg;

  typedef enum logic [2:0] {
    OFF   = 3'd0,
    DT_HL = 3'd1,
    LO_ON = 3'd2,
    DT_LH = 3'd3,
    HI_ON = 3'd4
  } pwm_dt_state_e;

endpackage

// File: rtl/pwm_deadtime_cnt.sv
// Loadable dead-time down-counter; holds at 1 and flags done there or on a zero load.
module pwm_deadtime_cnt #(
  parameter int DT_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_i,
  input  logic [DT_WIDTH-1:0] load_val_i,
  output logic                done_o
);

  localparam logic [DT_WIDTH-1:0] ONE = DT_WIDTH'(1);

  logic [DT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)           cnt_d = load_val_i;
    else if (cnt_q > ONE) cnt_d = cnt_q - ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // A zero load means "no dead time": report done in the same cycle.
  assign done_o = load_i ? (load_val_i == '0) : (cnt_q == ONE);

endmodule

// File: rtl/pwm_deadtime_out.sv
// Complementary gate driver with dead-time insertion, shadowed config and latched fault.
module pwm_deadtime_out
  import pwm_pkg::*;
#(
  parameter int                  DT_WIDTH          = 8,
  parameter logic [DT_WIDTH-1:0] DEFAULT_DT_CYCLES = 8'd4,
  parameter logic                RESET_ACT_LOW_H   = 1'b0,
  parameter logic                RESET_ACT_LOW_L   = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                pwm_raw,
  input  logic                period_end,
  input  logic [DT_WIDTH-1:0] deadtime_cycles_i,
  input  logic                act_low_h_i,
  input  logic                act_low_l_i,
  input  logic                fault_i,
  input  logic                fault_clr_i,
  output logic                pwm_h_o,
  output logic                pwm_l_o,
  output logic                in_deadtime_o,
  output logic                fault_o
);

  pwm_dt_state_e       state_q, state_d;
  logic [DT_WIDTH-1:0] dt_sh_q, dt_sh_d;
  logic                alh_sh_q, alh_sh_d, all_sh_q, all_sh_d;
  logic                fault_q, fault_d;
  logic                h_q, h_d, l_q, l_d, indt_q, indt_d;
  logic                shadow_ld, force_off, tmr_load, tmr_done;

  // Fault set dominates clear; the next-state value is used so outputs drop with the flag.
  assign fault_d   = fault_i ? 1'b1 : (fault_clr_i ? 1'b0 : fault_q);
  assign force_off = fault_d | ~enable;
  assign shadow_ld = (period_end & enable) | (state_q == OFF);

  always_comb begin
    dt_sh_d  = dt_sh_q;
    alh_sh_d = alh_sh_q;
    all_sh_d = all_sh_q;
    if (shadow_ld) begin
      dt_sh_d  = deadtime_cycles_i;
      alh_sh_d = act_low_h_i;
      all_sh_d = act_low_l_i;
    end
  end

  // Timer reloads on every entry into a dead state from a non-dead state.
  assign tmr_load = ~force_off & ((state_q == OFF) |
                                  ((state_q == LO_ON) &  pwm_raw) |
                                  ((state_q == HI_ON) & ~pwm_raw));

  pwm_deadtime_cnt #(.DT_WIDTH(DT_WIDTH)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (dt_sh_q),
    .done_o     (tmr_done)
  );

  always_comb begin
    state_d = state_q;
    if (force_off) state_d = OFF;
    else begin
      unique case (state_q)
        OFF:     state_d = pwm_raw ? (tmr_done ? HI_ON : DT_LH)
                                   : (tmr_done ? LO_ON : DT_HL);
        LO_ON:   if (pwm_raw)       state_d = tmr_done ? HI_ON : DT_LH;
        HI_ON:   if (!pwm_raw)      state_d = tmr_done ? LO_ON : DT_HL;
        DT_LH:   if (!pwm_raw)      state_d = LO_ON;
                 else if (tmr_done) state_d = HI_ON;
        DT_HL:   if (pwm_raw)       state_d = HI_ON;
                 else if (tmr_done) state_d = LO_ON;
        default: state_d = OFF;
      endcase
    end
  end

  assign h_d    = (state_d == HI_ON) ^ alh_sh_d;
  assign l_d    = (state_d == LO_ON) ^ all_sh_d;
  assign indt_d = (state_d == DT_LH) | (state_d == DT_HL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= OFF;
      dt_sh_q  <= DEFAULT_DT_CYCLES;
      alh_sh_q <= RESET_ACT_LOW_H;
      all_sh_q <= RESET_ACT_LOW_L;
      fault_q  <= 1'b0;
      h_q      <= RESET_ACT_LOW_H;
      l_q      <= RESET_ACT_LOW_L;
      indt_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dt_sh_q  <= dt_sh_d;
      alh_sh_q <= alh_sh_d;
      all_sh_q <= all_sh_d;
      fault_q  <= fault_d;
      h_q      <= h_d;
      l_q      <= l_d;
      indt_q   <= indt_d;
    end
  end

  assign pwm_h_o       = h_q;
  assign pwm_l_o       = l_q;
  assign in_deadtime_o = indt_q;
  assign fault_o       = fault_q;

endmodule

// File: tb/tb_pwm_deadtime_out.sv
// Directed bench for pwm_deadtime_out plus a short random overlap soak.
module tb_pwm_deadtime_out;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable, pwm_raw, period_end;
  logic [7:0] deadtime_cycles_i;
  logic       act_low_h_i, act_low_l_i, fault_i, fault_clr_i;
  logic       pwm_h_o, pwm_l_o, in_deadtime_o, fault_o;
  logic       soak_on = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pwm_deadtime_out dut (
    .clk               (clk),
    .rst               (rst),
    .enable            (enable),
    .pwm_raw           (pwm_raw),
    .period_end        (period_end),
    .deadtime_cycles_i (deadtime_cycles_i),
    .act_low_h_i       (act_low_h_i),
    .act_low_l_i       (act_low_l_i),
    .fault_i           (fault_i),
    .fault_clr_i       (fault_clr_i),
    .pwm_h_o           (pwm_h_o),
    .pwm_l_o           (pwm_l_o),
    .in_deadtime_o     (in_deadtime_o),
    .fault_o           (fault_o)
  );

  task automatic chk(input string tag, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic h, input logic l, input logic dt);
    chk({tag, ".h"}, pwm_h_o, h);
    chk({tag, ".l"}, pwm_l_o, l);
    chk({tag, ".dt"}, in_deadtime_o, dt);
  endtask

  // Polarity is held at 0 during the soak, so pins are the logical drives.
  always @(negedge clk)
    if (soak_on && !rst) assert (!(pwm_h_o && pwm_l_o));

  initial begin
    enable = 0; pwm_raw = 0; period_end = 0; deadtime_cycles_i = 8'd4;
    act_low_h_i = 0; act_low_l_i = 0; fault_i = 0; fault_clr_i = 0;
    #1 rst = 1;
    #2;
    chk_out("reset", 0, 0, 0);
    chk("reset.fault", fault_o, 0);
    @(negedge clk);
    rst = 0; enable = 1;

    // Start-up from OFF with raw=0 goes through DT_HL for 4 clks.
    tick();           chk_out("start.e1", 0, 0, 1);
    repeat (3) tick(); chk_out("start.e4", 0, 0, 1);
    tick();           chk_out("start.lo", 0, 1, 0);

    // Rising raw in LO_ON: l drops in 1 clk, h rises 4 later.
    pwm_raw = 1;
    tick();           chk_out("rise.e1", 0, 0, 1);
    repeat (3) tick(); chk_out("rise.e4", 0, 0, 1);
    tick();           chk_out("rise.hi", 1, 0, 0);

    pwm_raw = 0;
    tick();           chk_out("fall.e1", 0, 0, 1);
    repeat (3) tick(); chk_out("fall.e4", 0, 0, 1);
    tick();           chk_out("fall.lo", 0, 1, 0);

    // Short 2-clk high pulse aborts the dead time back to LO_ON.
    pwm_raw = 1;
    tick();           chk_out("pulse.e1", 0, 0, 1);
    tick();           chk_out("pulse.e2", 0, 0, 1);
    pwm_raw = 0;
    tick();           chk_out("pulse.back", 0, 1, 0);

    // dt=0: complements with 1-clk latency and no dead time.
    deadtime_cycles_i = 8'd0; period_end = 1;
    tick();
    period_end = 0;
    for (int i = 0; i < 8; i++) begin
      pwm_raw = (i % 4) < 2;
      tick();
      chk_out($sformatf("dt0.%0d", i), pwm_raw, !pwm_raw, 0);
    end
    pwm_raw = 0;
    tick();

    // Restore dt=4, then write dt=10 / act_low_h=1 mid-period.
    deadtime_cycles_i = 8'd4; period_end = 1;
    tick();
    period_end = 0;
    deadtime_cycles_i = 8'd10; act_low_h_i = 1;
    pwm_raw = 1;
    tick();           chk_out("cfg.old.e1", 0, 0, 1);
    repeat (3) tick();
    tick();           chk_out("cfg.old.hi", 1, 0, 0);
    pwm_raw = 0;
    tick();           chk_out("cfg.hl.e1", 0, 0, 1);
    period_end = 1;
    tick();           chk_out("cfg.pe", 1, 0, 1);
    period_end = 0;
    repeat (2) tick();
    tick();           chk_out("cfg.lo", 1, 1, 0);
    pwm_raw = 1;
    tick();           chk_out("cfg.new.e1", 1, 0, 1);
    repeat (9) tick(); chk_out("cfg.new.e10", 1, 0, 1);
    tick();           chk_out("cfg.new.hi", 0, 0, 0);

    // Restore dt=4 / polarity 0 while HI_ON, then fault.
    deadtime_cycles_i = 8'd4; act_low_h_i = 0; period_end = 1;
    tick();           chk_out("pol.back", 1, 0, 0);
    period_end = 0;
    fault_i = 1;
    tick();           chk_out("flt.set", 0, 0, 0);
    chk("flt.set.f", fault_o, 1);
    fault_i = 0;
    tick();           chk("flt.hold", fault_o, 1);
    fault_i = 1; fault_clr_i = 1;
    tick();           chk("flt.setwins", fault_o, 1);
    chk_out("flt.setwins", 0, 0, 0);
    fault_i = 0;
    tick();           chk("flt.clr", fault_o, 0);
    chk_out("flt.reentry", 0, 0, 1);
    fault_clr_i = 0;
    repeat (3) tick(); chk_out("flt.e4", 0, 0, 1);
    tick();           chk_out("flt.hi", 1, 0, 0);

    enable = 0;
    tick();           chk_out("dis", 0, 0, 0);

    // Async reset between edges while HI_ON.
    enable = 1;
    repeat (5) tick(); chk_out("pre_rst.hi", 1, 0, 0);
    #2 rst = 1;
    #1 chk_out("async_rst", 0, 0, 0);
    #2 rst = 0;
    tick();           chk_out("post_rst.e1", 0, 0, 1);

    // Random soak, polarity fixed at 0.
    soak_on = 1;
    for (int i = 0; i < 300; i++) begin
      enable            = ($urandom_range(0, 9) != 0);
      pwm_raw           = ($urandom_range(0, 3) == 0) ? ~pwm_raw : pwm_raw;
      fault_i           = ($urandom_range(0, 19) == 0);
      fault_clr_i       = ($urandom_range(0, 9) == 0);
      period_end        = ($urandom_range(0, 9) == 0);
      deadtime_cycles_i = 8'($urandom_range(0, 3));
      tick();
      chk("soak.overlap", pwm_h_o & pwm_l_o, 0);
      chk("soak.dt_idle", in_deadtime_o & (pwm_h_o | pwm_l_o), 0);
    end
    soak_on = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
